// File: rtl/census_xform_gen.sv
`default_nettype none
// ============================================================================
// Module   : census_xform_gen
// Brief    : Streaming census transform with configurable window and stride,
//            raster counters resynchronised by start-of-frame, and EOF flag.
// Revision : 1.0  initial release
// ============================================================================
module census_xform_gen #(
   parameter int PIX_W  = 8,
   parameter int WIN    = 5,
   parameter int STRIDE = 2,
   parameter int ROW_SZ = 320,
   parameter int COL_SZ = 240,
   localparam int K     = (WIN - 1) / STRIDE + 1,
   localparam int OUT_W = K * K - 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PIX_W-1:0] thresh,
   input  logic [PIX_W-1:0] in_val,
   input  logic             in_valid,
   input  logic             in_sof,
   output logic [OUT_W-1:0] out_code,
   output logic [9:0]       out_x,
   output logic [9:0]       out_y,
   output logic             out_valid,
   output logic             out_eof
);

   localparam int         c_H      = WIN / 2;
   localparam int         c_LB_LEN = ROW_SZ - WIN;
   localparam int         c_CI     = (c_H / STRIDE) * (K + 1);
   localparam logic [9:0] c_X_LAST = 10'(ROW_SZ - 1);
   localparam logic [9:0] c_Y_LAST = 10'(COL_SZ - 1);
   localparam logic [9:0] c_EDGE   = 10'(2 * c_H);
   localparam logic [9:0] c_HOFF   = 10'(c_H);
   localparam logic [9:0] c_EOF_X  = 10'(ROW_SZ - 1 - c_H);
   localparam logic [9:0] c_EOF_Y  = 10'(COL_SZ - 1 - c_H);

   logic [9:0]       r_cx, r_cy, w_cx, w_cy;
   logic [PIX_W-1:0] r_thr;
   logic             r_pend;
   logic [9:0]       r_px, r_py;
   logic             w_emit;
   logic [OUT_W-1:0] w_code;

   // Window row 0 is the oldest line; column WIN-1 holds the newest pixel.
   logic [PIX_W-1:0] r_win [WIN][WIN];
   logic [PIX_W-1:0] r_lb  [WIN-1][c_LB_LEN];

   // sof overrides the running position so the accepted pixel is (0,0).
   assign w_cx   = in_sof ? 10'd0 : r_cx;
   assign w_cy   = in_sof ? 10'd0 : r_cy;
   assign w_emit = in_valid && (w_cx >= c_EDGE) && (w_cy >= c_EDGE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cx   <= '0;
         r_cy   <= '0;
         r_thr  <= '0;
         r_pend <= 1'b0;
         r_px   <= '0;
         r_py   <= '0;
      end else begin
         r_pend <= w_emit;
         if (in_valid) begin
            if (in_sof) begin
               r_thr <= thresh;
            end
            if (w_cx == c_X_LAST) begin
               r_cx <= '0;
               r_cy <= (w_cy == c_Y_LAST) ? 10'd0 : w_cy + 10'd1;
            end else begin
               r_cx <= w_cx + 10'd1;
               r_cy <= w_cy;
            end
         end
         if (w_emit) begin
            r_px <= w_cx - c_HOFF;
            r_py <= w_cy - c_HOFF;
         end
      end
   end

   // Window + line buffer form a ROW_SZ-deep delay between adjacent window rows.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN - 1; c++) begin
               r_win[r][c] <= r_win[r][c+1];
            end
         end
         r_win[WIN-1][WIN-1] <= in_val;
         for (int r = 0; r < WIN - 1; r++) begin
            r_win[r][WIN-1] <= r_lb[r][c_LB_LEN-1];
            r_lb[r][0]      <= r_win[r+1][0];
            for (int k = 1; k < c_LB_LEN; k++) begin
               r_lb[r][k] <= r_lb[r][k-1];
            end
         end
      end
   end

   // Compare in PIX_W+1 bits so neighbour + threshold cannot wrap.
   for (genvar i = 0; i < K; i++) begin : g_cmp_row
      for (genvar j = 0; j < K; j++) begin : g_cmp_col
         if (i * K + j != c_CI) begin : g_pt
            localparam int c_B = (i * K + j > c_CI) ? i * K + j - 1 : i * K + j;
            assign w_code[c_B] = ({1'b0, r_win[i*STRIDE][j*STRIDE]} + {1'b0, r_thr})
                                 < {1'b0, r_win[c_H][c_H]};
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_eof   <= 1'b0;
         out_code  <= '0;
         out_x     <= '0;
         out_y     <= '0;
      end else begin
         out_valid <= r_pend;
         out_eof   <= r_pend && (r_px == c_EOF_X) && (r_py == c_EOF_Y);
         if (r_pend) begin
            out_code <= w_code;
            out_x    <= r_px;
            out_y    <= r_py;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_census_xform_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_census_xform_gen
// Brief    : Directed self-checking bench for census_xform_gen (sparse 5x5 and
//            dense 3x3 instances on an 8x6 frame).
// Revision : 1.0  initial release
// ============================================================================
module tb_census_xform_gen;

   localparam int RS = 8;
   localparam int CS = 6;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] thresh, in_val;
   logic       in_valid, in_sof;

   logic [7:0] out_code, d_code;
   logic [9:0] out_x, out_y, d_x, d_y;
   logic       out_valid, out_eof, d_valid, d_eof;

   census_xform_gen #(.PIX_W(8), .WIN(5), .STRIDE(2), .ROW_SZ(RS), .COL_SZ(CS)) dut (
      .clk(clk), .reset(reset), .thresh(thresh), .in_val(in_val), .in_valid(in_valid),
      .in_sof(in_sof), .out_code(out_code), .out_x(out_x), .out_y(out_y),
      .out_valid(out_valid), .out_eof(out_eof));

   census_xform_gen #(.PIX_W(8), .WIN(3), .STRIDE(1), .ROW_SZ(RS), .COL_SZ(CS)) dut_d (
      .clk(clk), .reset(reset), .thresh(thresh), .in_val(in_val), .in_valid(in_valid),
      .in_sof(in_sof), .out_code(d_code), .out_x(d_x), .out_y(d_y),
      .out_valid(d_valid), .out_eof(d_eof));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;
   int stray_eof = 0;
   int pix [CS][RS];

   logic [7:0] q_code[$], dq_code[$];
   logic [9:0] q_x[$], q_y[$], dq_x[$], dq_y[$];
   logic       q_eof[$];
   int         q_cyc[$];

   always @(negedge clk) begin
      if (out_valid) begin
         q_code.push_back(out_code);
         q_x.push_back(out_x);
         q_y.push_back(out_y);
         q_eof.push_back(out_eof);
         q_cyc.push_back(cyc);
      end
      if (out_eof && !out_valid) stray_eof++;
      if (d_valid) begin
         dq_code.push_back(d_code);
         dq_x.push_back(d_x);
         dq_y.push_back(d_y);
      end
   end

   task automatic step(input logic [7:0] v, input logic sof, input logic vld);
      in_val = v; in_sof = sof; in_valid = vld;
      @(posedge clk); #1;
   endtask

   task automatic clear_q();
      q_code.delete(); q_x.delete(); q_y.delete(); q_eof.delete(); q_cyc.delete();
      dq_code.delete(); dq_x.delete(); dq_y.delete();
      stray_eof = 0;
   endtask

   // Streams the first n_pix raster pixels of pix[][]; idle gaps carry a bogus sof/thresh.
   task automatic feed(input int n_pix, input logic [7:0] thr0, input logic [7:0] thr1,
                       input bit gaps, output int acc44);
      acc44 = -1;
      for (int i = 0; i < n_pix; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               thresh = 8'($urandom_range(0, 255));
               step(8'($urandom_range(0, 255)), 1'b1, 1'b0);
            end
         end
         thresh = (i == 0) ? thr0 : thr1;
         step(8'(pix[i / RS][i % RS]), 1'(i == 0), 1'b1);
         if (i == 4 * RS + 4) acc44 = cyc;
      end
      in_valid = 1'b0; in_sof = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] gold_dense(input int x, input int y, input int thr);
      logic [7:0] c;
      int n;
      c = '0; n = 0;
      for (int dy = -1; dy <= 1; dy++) begin
         for (int dx = -1; dx <= 1; dx++) begin
            if (dy != 0 || dx != 0) begin
               c[n] = (pix[y+dy][x+dx] + thr < pix[y][x]);
               n++;
            end
         end
      end
      return c;
   endfunction

   task automatic test_reset();
      logic [29:0] obs;
      #2 reset = 1'b0;
      #2;
      obs = {out_code, out_x, out_y, out_valid, out_eof};
      n_checks++;
      if (obs !== 30'd0) $display("FAIL reset_outputs: got %h, expected 0", obs); else n_pass++;
      in_valid = 1'b1; in_val = 8'd77;
      @(posedge clk); @(posedge clk); #1;
      obs = {out_code, out_x, out_y, out_valid, out_eof};
      n_checks++;
      if (obs !== 30'd0) $display("FAIL reset_held: got %h, expected 0", obs); else n_pass++;
      obs = {d_code, d_x, d_y, d_valid, d_eof};
      n_checks++;
      if (obs !== 30'd0) $display("FAIL reset_dense: got %h, expected 0", obs); else n_pass++;
      in_valid = 1'b0;
      #2 reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_ramp();
      int a44;
      logic [28:0] obs, exp;
      for (int y = 0; y < CS; y++) for (int x = 0; x < RS; x++) pix[y][x] = 10 * y + x;
      clear_q();
      feed(48, 8'd0, 8'd0, 1'b0, a44);
      n_checks++;
      if (q_code.size() != 8) $display("FAIL ramp_count: got %0d, expected 8", q_code.size());
      else n_pass++;
      for (int k = 0; k < q_code.size() && k < 8; k++) begin
         obs = {q_code[k], q_x[k], q_y[k], q_eof[k]};
         exp = {8'h0F, 10'(2 + k % 4), 10'(2 + k / 4), 1'(k == 7)};
         n_checks++;
         if (obs !== exp) $display("FAIL ramp_strobe%0d: got %h, expected %h", k, obs, exp);
         else n_pass++;
      end
      n_checks++;
      if (q_cyc.size() == 0 || q_cyc[0] != a44 + 1)
         $display("FAIL ramp_latency: got cycle %0d, expected %0d",
                  (q_cyc.size() == 0) ? -1 : q_cyc[0], a44 + 1);
      else n_pass++;
      n_checks++;
      if (stray_eof != 0) $display("FAIL ramp_stray_eof: got %0d, expected 0", stray_eof);
      else n_pass++;
   endtask

   task automatic test_flat();
      int a;
      int thr_t [4] = '{5, 3, 2, 0};
      int live_t[4] = '{0, 0, 200, 200};
      logic [7:0] cen_t[4] = '{8'h00, 8'h00, 8'hFF, 8'hFF};
      logic [27:0] obs, exp;
      for (int y = 0; y < CS; y++) for (int x = 0; x < RS; x++) pix[y][x] = 100;
      clear_q();
      feed(48, 8'd0, 8'd0, 1'b0, a);
      n_checks++;
      if (q_code.size() != 8) $display("FAIL flat_count: got %0d, expected 8", q_code.size());
      else n_pass++;
      for (int k = 0; k < q_code.size() && k < 8; k++) begin
         n_checks++;
         if (q_code[k] !== 8'h00) $display("FAIL flat_code%0d: got %h, expected 00", k, q_code[k]);
         else n_pass++;
      end
      // Zero image with one centre of 3 at (4,2); threshold latched at sof, live port differs.
      for (int t = 0; t < 4; t++) begin
         for (int y = 0; y < CS; y++) for (int x = 0; x < RS; x++) pix[y][x] = 0;
         pix[2][4] = 3;
         clear_q();
         feed(48, 8'(thr_t[t]), 8'(live_t[t]), 1'b0, a);
         n_checks++;
         if (q_code.size() != 8) $display("FAIL thr%0d_count: got %0d, expected 8", thr_t[t], q_code.size());
         else n_pass++;
         for (int k = 0; k < q_code.size() && k < 8; k++) begin
            obs = {q_code[k], q_x[k], q_y[k]};
            exp = {(k == 2) ? cen_t[t] : 8'h00, 10'(2 + k % 4), 10'(2 + k / 4)};
            n_checks++;
            if (obs !== exp) $display("FAIL thr%0d_strobe%0d: got %h, expected %h", thr_t[t], k, obs, exp);
            else n_pass++;
         end
      end
   endtask

   task automatic test_gaps();
      int a44;
      logic [28:0] obs, exp;
      for (int y = 0; y < CS; y++) for (int x = 0; x < RS; x++) pix[y][x] = 10 * y + x;
      clear_q();
      feed(48, 8'd0, 8'd0, 1'b1, a44);
      n_checks++;
      if (q_code.size() != 8) $display("FAIL gaps_count: got %0d, expected 8", q_code.size());
      else n_pass++;
      for (int k = 0; k < q_code.size() && k < 8; k++) begin
         obs = {q_code[k], q_x[k], q_y[k], q_eof[k]};
         exp = {8'h0F, 10'(2 + k % 4), 10'(2 + k / 4), 1'(k == 7)};
         n_checks++;
         if (obs !== exp) $display("FAIL gaps_strobe%0d: got %h, expected %h", k, obs, exp);
         else n_pass++;
      end
      n_checks++;
      if (q_cyc.size() == 0 || q_cyc[0] != a44 + 1)
         $display("FAIL gaps_latency: got cycle %0d, expected %0d",
                  (q_cyc.size() == 0) ? -1 : q_cyc[0], a44 + 1);
      else n_pass++;
   endtask

   task automatic test_mid_sof();
      int a, a44;
      logic [28:0] obs, exp;
      for (int y = 0; y < CS; y++) for (int x = 0; x < RS; x++) pix[y][x] = 10 * y + x;
      clear_q();
      feed(27, 8'd0, 8'd0, 1'b0, a);
      // Reversed ramp: below/right neighbours are smaller, giving 8'hF0.
      for (int y = 0; y < CS; y++) for (int x = 0; x < RS; x++) pix[y][x] = 60 - (10 * y + x);
      feed(48, 8'd0, 8'd255, 1'b0, a44);
      n_checks++;
      if (q_code.size() != 8) $display("FAIL midsof_count: got %0d, expected 8", q_code.size());
      else n_pass++;
      n_checks++;
      if (q_cyc.size() == 0 || q_cyc[0] != a44 + 1)
         $display("FAIL midsof_first: got cycle %0d, expected %0d",
                  (q_cyc.size() == 0) ? -1 : q_cyc[0], a44 + 1);
      else n_pass++;
      for (int k = 0; k < q_code.size() && k < 8; k++) begin
         obs = {q_code[k], q_x[k], q_y[k], q_eof[k]};
         exp = {8'hF0, 10'(2 + k % 4), 10'(2 + k / 4), 1'(k == 7)};
         n_checks++;
         if (obs !== exp) $display("FAIL midsof_strobe%0d: got %h, expected %h", k, obs, exp);
         else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      int a;
      logic [28:0] obs, exp;
      for (int y = 0; y < CS; y++) for (int x = 0; x < RS; x++) pix[y][x] = 10 * y + x;
      clear_q();
      feed(40, 8'd0, 8'd0, 1'b0, a);
      obs = {out_code, out_x, out_y, out_valid};
      n_checks++;
      if (obs !== {8'h0F, 10'd5, 10'd2, 1'b0}) $display("FAIL hold_outputs: got %h, expected %h",
                                                       obs, {8'h0F, 10'd5, 10'd2, 1'b0});
      else n_pass++;
      #3 reset = 1'b0;
      #1;
      obs = {out_code, out_x, out_y, out_valid};
      n_checks++;
      if (obs !== 29'd0 || out_eof !== 1'b0) $display("FAIL async_reset: got %h, expected 0", obs);
      else n_pass++;
      @(posedge clk);
      #3 reset = 1'b1;
      @(posedge clk); #1;
      clear_q();
      feed(48, 8'd0, 8'd0, 1'b0, a);
      n_checks++;
      if (q_code.size() != 8) $display("FAIL post_reset_count: got %0d, expected 8", q_code.size());
      else n_pass++;
      for (int k = 0; k < q_code.size() && k < 8; k++) begin
         obs = {q_code[k], q_x[k], q_y[k], q_eof[k]};
         exp = {8'h0F, 10'(2 + k % 4), 10'(2 + k / 4), 1'(k == 7)};
         n_checks++;
         if (obs !== exp) $display("FAIL post_reset_strobe%0d: got %h, expected %h", k, obs, exp);
         else n_pass++;
      end
   endtask

   task automatic test_dense();
      int a;
      logic [27:0] obs, exp;
      for (int y = 0; y < CS; y++) for (int x = 0; x < RS; x++) pix[y][x] = $urandom_range(0, 255);
      clear_q();
      feed(48, 8'd7, 8'($urandom_range(0, 255)), 1'b0, a);
      n_checks++;
      if (dq_code.size() != 24) $display("FAIL dense_count: got %0d, expected 24", dq_code.size());
      else n_pass++;
      for (int k = 0; k < dq_code.size() && k < 24; k++) begin
         obs = {dq_code[k], dq_x[k], dq_y[k]};
         exp = {gold_dense(1 + k % 6, 1 + k / 6, 7), 10'(1 + k % 6), 10'(1 + k / 6)};
         n_checks++;
         if (obs !== exp) $display("FAIL dense_strobe%0d: got %h, expected %h", k, obs, exp);
         else n_pass++;
      end
   endtask

   initial begin
      reset = 1'b1; thresh = '0; in_val = '0; in_valid = 1'b0; in_sof = 1'b0;
      test_reset();
      test_ramp();
      test_flat();
      test_gaps();
      test_mid_sof();
      test_async_reset();
      test_dense();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
